// File: rtl/mem_result_checker_if.sv
// Bundles the table-programming port, run control, memory read port and
// status outputs of the memory result checker.
interface mem_result_checker_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int N_CHECKS = 10
);
    localparam int IW = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;
    localparam int CW = $clog2(N_CHECKS + 1);

    logic              start;
    logic              cfg_we;
    logic [IW-1:0]     cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_ne;
    logic              cfg_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_CHECKS-1:0] fail_mask;
    logic [CW-1:0]     fail_count;
    logic [IW-1:0]     first_fail_idx;

    modport master (
        output start, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_ne, cfg_en, rd_data,
        input  rd_en, rd_addr, busy, done, pass, fail_mask, fail_count, first_fail_idx
    );

    modport slave (
        input  start, cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_ne, cfg_en, rd_data,
        output rd_en, rd_addr, busy, done, pass, fail_mask, fail_count, first_fail_idx
    );
endinterface

// File: rtl/mem_result_checker.sv
// Post-run memory sweep: waits out a drain delay, then reads each table entry
// once and accumulates pass/fail status against the programmed expectations.
module mem_result_checker #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int N_CHECKS    = 10,
    parameter int WAIT_CYCLES = 85,
    parameter int RD_LAT      = 0
) (
    input logic clk,
    input logic reset,
    mem_result_checker_if.slave bus
);
    localparam int IW  = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;
    localparam int CW  = $clog2(N_CHECKS + 1);
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int LW  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [WCW-1:0]      wait_q, wait_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [N_CHECKS-1:0] mask_q, mask_d;
    logic [CW-1:0]       count_q, count_d;
    logic [IW-1:0]       first_q, first_d;
    logic [ADDR_W-1:0]   hold_q, hold_d;

    logic [ADDR_W-1:0]   tbl_addr_q [N_CHECKS];
    logic [DATA_W-1:0]   tbl_data_q [N_CHECKS];
    logic [N_CHECKS-1:0] tbl_ne_q;
    logic [N_CHECKS-1:0] tbl_en_q;

    logic busy, cfg_ok, fail;

    assign busy   = (state_q == S_WAIT) || (state_q == S_READ);
    assign cfg_ok = bus.cfg_we && !busy && (int'(bus.cfg_idx) < N_CHECKS);
    assign fail   = tbl_en_q[idx_q] && (tbl_ne_q[idx_q] ? (bus.rd_data == tbl_data_q[idx_q])
                                                        : (bus.rd_data != tbl_data_q[idx_q]));

    // Only the enables need a reset; stale addr/data of a disabled entry are harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_en_q <= '0;
        end else if (cfg_ok) begin
            tbl_en_q[bus.cfg_idx] <= bus.cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            tbl_addr_q[bus.cfg_idx] <= bus.cfg_addr;
            tbl_data_q[bus.cfg_idx] <= bus.cfg_data;
            tbl_ne_q[bus.cfg_idx]   <= bus.cfg_ne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            first_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            first_q <= first_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        mask_d  = mask_q;
        count_d = count_q;
        first_d = first_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mask_d  = '0;
                    count_d = '0;
                    first_d = '0;
                    idx_d   = '0;
                    lat_d   = '0;
                    wait_d  = WCW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == WCW'(1)) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    lat_d   = '0;
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            S_READ: begin
                hold_d = tbl_addr_q[idx_q];
                // Compare only in the final cycle of the slot, when read data has arrived.
                if (lat_q == LW'(RD_LAT)) begin
                    lat_d = '0;
                    if (fail) begin
                        mask_d[idx_q] = 1'b1;
                        count_d       = count_q + CW'(1);
                        if (count_q == '0) first_d = idx_q;
                    end
                    if (idx_q == IW'(N_CHECKS - 1)) state_d = S_DONE;
                    else                            idx_d   = idx_q + IW'(1);
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rd_en          = (state_q == S_READ);
    assign bus.rd_addr        = (state_q == S_READ) ? tbl_addr_q[idx_q] : hold_q;
    assign bus.busy           = busy;
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass           = (state_q == S_DONE) && (count_q == '0);
    assign bus.fail_mask      = mask_q;
    assign bus.fail_count     = count_q;
    assign bus.first_fail_idx = first_q;
endmodule

// File: tb/tb_mem_result_checker.sv
// Runs three checker configurations in lockstep on a shared table and memory
// and compares their status and timing against a behavioural model.
module tb_mem_result_checker;
    localparam int N  = 10;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start, cfg_we, cfg_ne, cfg_en;
    logic [3:0]    cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [DW-1:0] mem [128];
    logic [DW-1:0] pb1, pb2;

    mem_result_checker_if #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N)) ifa ();
    mem_result_checker_if #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N)) ifb ();
    mem_result_checker_if #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N)) ifc ();

    mem_result_checker #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N), .WAIT_CYCLES(85), .RD_LAT(0))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    mem_result_checker #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N), .WAIT_CYCLES(85), .RD_LAT(2))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    mem_result_checker #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N), .WAIT_CYCLES(0), .RD_LAT(0))
        dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    assign ifa.start = start;    assign ifb.start = start;    assign ifc.start = start;
    assign ifa.cfg_we = cfg_we;  assign ifb.cfg_we = cfg_we;  assign ifc.cfg_we = cfg_we;
    assign ifa.cfg_idx = cfg_idx; assign ifb.cfg_idx = cfg_idx; assign ifc.cfg_idx = cfg_idx;
    assign ifa.cfg_addr = cfg_addr; assign ifb.cfg_addr = cfg_addr; assign ifc.cfg_addr = cfg_addr;
    assign ifa.cfg_data = cfg_data; assign ifb.cfg_data = cfg_data; assign ifc.cfg_data = cfg_data;
    assign ifa.cfg_ne = cfg_ne;  assign ifb.cfg_ne = cfg_ne;  assign ifc.cfg_ne = cfg_ne;
    assign ifa.cfg_en = cfg_en;  assign ifb.cfg_en = cfg_en;  assign ifc.cfg_en = cfg_en;

    // Combinational memory for a/c, two-stage registered memory for b.
    assign ifa.rd_data = mem[ifa.rd_addr[6:0]];
    assign ifc.rd_data = mem[ifc.rd_addr[6:0]];
    always @(posedge clk) begin
        pb1 <= mem[ifb.rd_addr[6:0]];
        pb2 <= pb1;
    end
    assign ifb.rd_data = pb2;

    logic [2:0]    o_done, o_pass, o_busy, o_rden;
    logic [N-1:0]  o_mask  [3];
    logic [3:0]    o_count [3];
    logic [3:0]    o_first [3];
    logic [AW-1:0] o_addr  [3];
    assign o_done = {ifc.done, ifb.done, ifa.done};
    assign o_pass = {ifc.pass, ifb.pass, ifa.pass};
    assign o_busy = {ifc.busy, ifb.busy, ifa.busy};
    assign o_rden = {ifc.rd_en, ifb.rd_en, ifa.rd_en};
    assign o_mask[0] = ifa.fail_mask;  assign o_mask[1] = ifb.fail_mask;  assign o_mask[2] = ifc.fail_mask;
    assign o_count[0] = ifa.fail_count; assign o_count[1] = ifb.fail_count; assign o_count[2] = ifc.fail_count;
    assign o_first[0] = ifa.first_fail_idx; assign o_first[1] = ifb.first_fail_idx; assign o_first[2] = ifc.first_fail_idx;
    assign o_addr[0] = ifa.rd_addr;    assign o_addr[1] = ifb.rd_addr;    assign o_addr[2] = ifc.rd_addr;

    // Expected edges from the start edge to done, and to the first read.
    int lat_done [3] = '{85 + 10, 85 + 30, 10};
    int lat_rd   [3] = '{85, 85, 0};

    int m_addr [N];
    logic [DW-1:0] m_data [N];
    logic m_ne [N];
    logic m_en [N];

    int checks = 0;
    int failures = 0;

    task automatic compute(output logic [N-1:0] em, output int ec, output int ef);
        em = '0; ec = 0; ef = 0;
        for (int i = 0; i < N; i++) begin
            logic same;
            same = (mem[m_addr[i]] == m_data[i]);
            if (m_en[i] && (m_ne[i] ? same : !same)) begin
                if (ec == 0) ef = i;
                em[i] = 1'b1;
                ec++;
            end
        end
    endtask

    task automatic drive_cfg(input int i, input int a, input logic [DW-1:0] d, input logic ne, input logic en);
        cfg_idx = 4'(i); cfg_addr = AW'(a); cfg_data = d; cfg_ne = ne; cfg_en = en;
    endtask

    task automatic write_entry(input int i, input int a, input logic [DW-1:0] d, input logic ne, input logic en);
        drive_cfg(i, a, d, ne, en);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        if (i < N) begin
            m_addr[i] = a; m_data[i] = d; m_ne[i] = ne; m_en[i] = en;
        end
    endtask

    // race: 0 none, 1 start pulse while busy, 2 cfg write while busy, 3 cfg write with start
    task automatic run(input string name, input int race);
        logic [N-1:0] em;
        int ec, ef, k;
        int d_done [3];
        int d_rd [3];
        if (race == 3) begin
            drive_cfg(9, 70, 32'h0000_0293, 1'b1, 1'b1);
            cfg_we = 1'b1;
            m_addr[9] = 70; m_data[9] = 32'h0000_0293; m_ne[9] = 1'b1; m_en[9] = 1'b1;
        end
        compute(em, ec, ef);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b0;
        k = cyc;
        for (int d = 0; d < 3; d++) begin
            d_done[d] = -1;
            d_rd[d] = -1;
        end
        checks++;
        if (o_busy !== 3'b111 || o_done !== 3'b000 || o_count[0] !== 4'd0 || o_mask[0] !== '0) begin
            failures++;
            $display("FAIL %s start_status busy=%b done=%b cnt=%0d mask=%h, want busy=111 done=000 cnt=0 mask=0",
                     name, o_busy, o_done, o_count[0], o_mask[0]);
        end
        for (int t = 0; t <= 200; t++) begin
            for (int d = 0; d < 3; d++) begin
                if (o_rden[d] && d_rd[d] < 0) d_rd[d] = cyc - k;
                if (o_done[d] && d_done[d] < 0) d_done[d] = cyc - k;
            end
            if (o_done == 3'b111) break;
            if (race == 1) start = (t == 3);
            if (race == 2) begin
                cfg_we = (t == 3);
                drive_cfg(0, m_addr[0], mem[m_addr[0]], 1'b1, 1'b1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        cfg_we = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (d_done[d] != lat_done[d]) begin
                failures++;
                $display("FAIL %s dut%0d done_latency got %0d want %0d", name, d, d_done[d], lat_done[d]);
            end
            checks++;
            if (d_rd[d] != lat_rd[d]) begin
                failures++;
                $display("FAIL %s dut%0d first_rd_en got %0d want %0d", name, d, d_rd[d], lat_rd[d]);
            end
            checks++;
            if (o_pass[d] !== (ec == 0) || o_busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s dut%0d pass/busy got %b/%b want %b/0", name, d, o_pass[d], o_busy[d], ec == 0);
            end
            checks++;
            if (o_mask[d] !== em || o_count[d] !== 4'(ec) || o_first[d] !== 4'(ef)) begin
                failures++;
                $display("FAIL %s dut%0d status got mask=%h cnt=%0d first=%0d want mask=%h cnt=%0d first=%0d",
                         name, d, o_mask[d], o_count[d], o_first[d], em, ec, ef);
            end
        end
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_busy[d] !== 1'b0 || o_done[d] !== 1'b0 || o_pass[d] !== 1'b0 || o_rden[d] !== 1'b0 ||
                o_mask[d] !== '0 || o_count[d] !== 4'd0 || o_first[d] !== 4'd0 || o_addr[d] !== '0) begin
                failures++;
                $display("FAIL %s dut%0d outputs busy=%b done=%b pass=%b rd_en=%b mask=%h cnt=%0d first=%0d addr=%h, want all 0",
                         name, d, o_busy[d], o_done[d], o_pass[d], o_rden[d], o_mask[d], o_count[d], o_first[d], o_addr[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_en[i] = 1'b0;
        check_zero("reset");
    endtask

    task automatic test_all_pass();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[5] = 32'hC4FF_2000; mem[15] = 32'h4424_C000; mem[25] = 32'hC4AC_C000;
        mem[30] = 32'h1234_5678; mem[70] = 32'h0000_0293;
        write_entry(0, 5,  32'hC4FF_2000, 1'b0, 1'b1);
        write_entry(1, 15, 32'h4424_C000, 1'b0, 1'b1);
        write_entry(2, 25, 32'hC4AC_C000, 1'b0, 1'b1);
        write_entry(3, 30, 32'h0000_0293, 1'b1, 1'b1);
        write_entry(4, 70, 32'h0000_0293, 1'b0, 1'b1);
        write_entry(12, 70, 32'h0000_0293, 1'b1, 1'b1);
        run("all_pass", 0);
    endtask

    task automatic test_single_fail();
        mem[25] = 32'hC4AC_C001;
        run("single_fail", 0);
    endtask

    task automatic test_compare_modes();
        write_entry(5, 70, 32'h0000_0293, 1'b1, 1'b1);
        write_entry(6, 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run("compare_modes", 0);
    endtask

    task automatic test_reset_mid_run();
        int k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = cyc;
        while (cyc - k < 89) @(negedge clk);
        checks++;
        if (o_rden[0] !== 1'b1 || o_addr[0] !== AW'(m_addr[4])) begin
            failures++;
            $display("FAIL mid_run entry4_read rd_en=%b addr=%h want 1/%h", o_rden[0], o_addr[0], m_addr[4]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_en[i] = 1'b0;
        check_zero("mid_run_reset");
        run("rerun_after_reset", 0);
    endtask

    task automatic test_races();
        write_entry(0, 25, mem[25], 1'b0, 1'b1);
        write_entry(1, 30, 32'h0, 1'b0, 1'b1);
        run("start_while_busy", 1);
        run("cfg_while_busy", 2);
        run("cfg_with_start", 3);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 128; i++) mem[i] = $urandom;
            for (int i = 0; i < N; i++) begin
                int a;
                a = $urandom_range(0, 127);
                write_entry(i, a, ($urandom_range(0, 1) != 0) ? mem[a] : 32'($urandom),
                            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            end
            run($sformatf("random%0d", r), r % 3);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_we = 1'b0;
        drive_cfg(0, 0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 128; i++) mem[i] = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = 0; m_data[i] = '0; m_ne[i] = 1'b0; m_en[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_all_pass();
        test_single_fail();
        test_compare_modes();
        test_reset_mid_run();
        test_races();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
